// File: rtl/red_seq_pkg.sv
// Shared types and encodings for the red_sequencer instruction sequencer.
package red_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    CL_ADDI,
    CL_BNE,
    CL_EBREAK,
    CL_ILLEGAL
  } iclass_t;

  localparam logic [6:0]  OP_IMM       = 7'b0010011;
  localparam logic [6:0]  OP_BRANCH    = 7'b1100011;
  localparam logic [2:0]  F3_ADDI      = 3'b000;
  localparam logic [2:0]  F3_BNE       = 3'b001;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  localparam logic [2:0]  ALU_ADD      = 3'b000;
  localparam logic [2:0]  ALU_SUB      = 3'b001;

endpackage

// File: rtl/red_sequencer_if.sv
// Instruction-fetch handshake between the sequencer (master) and instruction memory (slave).
interface red_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  instr_req;
  logic [DATA_WIDTH-1:0] instr_addr;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr_rdata;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_valid,
    input  instr_rdata
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_valid,
    output instr_rdata
  );
endinterface

// File: rtl/red_decode.sv
// Combinational instruction decoder: register fields, immediate, ALU controls and class.
module red_decode
  import red_seq_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int ALUctrl_WIDTH = 3,
  parameter int DATA_WIDTH    = 32
) (
  input  logic [DATA_WIDTH-1:0]    ir,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]    imm,
  output logic                     alu_src,
  output logic [ALUctrl_WIDTH-1:0] alu_ctrl,
  output iclass_t                  iclass
);

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_b;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign rs1    = ADDRESS_WIDTH'(ir[19:15]);
  assign rs2    = ADDRESS_WIDTH'(ir[24:20]);
  assign rd     = ADDRESS_WIDTH'(ir[11:7]);
  assign imm_i  = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
  assign imm_b  = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  always_comb begin
    iclass   = CL_ILLEGAL;
    imm      = '0;
    alu_src  = 1'b0;
    alu_ctrl = ALUctrl_WIDTH'(ALU_ADD);
    if (opcode == OP_IMM && funct3 == F3_ADDI) begin
      iclass   = CL_ADDI;
      imm      = imm_i;
      alu_src  = 1'b1;
      alu_ctrl = ALUctrl_WIDTH'(ALU_ADD);
    end else if (opcode == OP_BRANCH && funct3 == F3_BNE) begin
      iclass   = CL_BNE;
      imm      = imm_b;
      alu_src  = 1'b0;
      alu_ctrl = ALUctrl_WIDTH'(ALU_SUB);
    end else if (ir == DATA_WIDTH'(EBREAK_INSTR)) begin
      iclass   = CL_EBREAK;
    end
  end

endmodule

// File: rtl/red_sequencer.sv
// Fetch/decode/execute sequencer for an ADDI/BNE/EBREAK subset driving an external datapath.
//
// state     | meaning
// ST_IDLE   | out of reset, waiting for start
// ST_FETCH  | instr_req high at pc until instr_valid, then IR captured
// ST_DECODE | decode fields driven from IR
// ST_EXEC   | register write / pc update / stop decision
// ST_HALT   | stopped (EBREAK or illegal), start restarts from pc 0
module red_sequencer
  import red_seq_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int ALUctrl_WIDTH = 3,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  red_sequencer_if.master          bus,
  input  logic                     EQ,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic                     RegWrite,
  output logic                     ALUsrc,
  output logic [ALUctrl_WIDTH-1:0] ALUctrl,
  output logic [DATA_WIDTH-1:0]    pc,
  output logic                     busy,
  output logic                     halted,
  output logic                     illegal
);

  state_t                   state;
  state_t                   state_next;
  logic [DATA_WIDTH-1:0]    ir;
  logic [ADDRESS_WIDTH-1:0] dec_rs1;
  logic [ADDRESS_WIDTH-1:0] dec_rs2;
  logic [ADDRESS_WIDTH-1:0] dec_rd;
  logic [DATA_WIDTH-1:0]    dec_imm;
  logic                     dec_alu_src;
  logic [ALUctrl_WIDTH-1:0] dec_alu_ctrl;
  iclass_t                  dec_class;
  logic [DATA_WIDTH-1:0]    pc_plus4;
  logic [DATA_WIDTH-1:0]    branch_target;
  logic                     taken;
  logic                     bad_target;

  red_decode #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .ALUctrl_WIDTH (ALUctrl_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_decode (
    .ir       (ir),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .imm      (dec_imm),
    .alu_src  (dec_alu_src),
    .alu_ctrl (dec_alu_ctrl),
    .iclass   (dec_class)
  );

  // Modulo-2^DATA_WIDTH arithmetic falls out of the fixed-width adders.
  assign pc_plus4      = pc + DATA_WIDTH'(4);
  assign branch_target = pc + dec_imm;
  assign taken         = (dec_class == CL_BNE) && !EQ;
  assign bad_target    = taken && branch_target[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_FETCH;
      ST_FETCH:  if (bus.instr_valid) state_next = ST_DECODE;
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        case (dec_class)
          CL_ADDI: state_next = ST_FETCH;
          CL_BNE:  state_next = bad_target ? ST_HALT : ST_FETCH;
          default: state_next = ST_HALT;
        endcase
      end
      ST_HALT:   if (start) state_next = ST_FETCH;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir      <= '0;
      pc      <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: if (bus.instr_valid) ir <= bus.instr_rdata;
        ST_EXEC: begin
          case (dec_class)
            CL_ADDI: pc <= pc_plus4;
            CL_BNE: begin
              if (!taken)          pc      <= pc_plus4;
              else if (bad_target) illegal <= 1'b1;
              else                 pc      <= branch_target;
            end
            CL_EBREAK: illegal <= 1'b0;
            default:   illegal <= 1'b1;
          endcase
        end
        ST_HALT: begin
          if (start) begin
            pc      <= '0;
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Decode fields are only presented while the instruction is in flight.
  always_comb begin
    bus.instr_req = 1'b0;
    busy          = 1'b0;
    halted        = 1'b0;
    RegWrite      = 1'b0;
    rs1           = '0;
    rs2           = '0;
    rd            = '0;
    ImmOp         = '0;
    ALUsrc        = 1'b0;
    ALUctrl       = '0;
    case (state)
      ST_FETCH: begin
        bus.instr_req = 1'b1;
        busy          = 1'b1;
      end
      ST_DECODE, ST_EXEC: begin
        busy    = 1'b1;
        rs1     = dec_rs1;
        rs2     = dec_rs2;
        rd      = dec_rd;
        ImmOp   = dec_imm;
        ALUsrc  = dec_alu_src;
        ALUctrl = dec_alu_ctrl;
        RegWrite = (state == ST_EXEC) && (dec_class == CL_ADDI) && (dec_rd != '0);
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.instr_addr = pc;

endmodule

// File: tb/tb_red_sequencer.sv
// Directed self-checking bench for red_sequencer; the bench plays instruction memory.
module tb_red_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        EQ;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] ImmOp;
  logic        RegWrite, ALUsrc;
  logic [2:0]  ALUctrl;
  logic [31:0] pc;
  logic        busy, halted, illegal;

  int checks = 0;
  int errors = 0;

  red_sequencer_if #(.DATA_WIDTH(32)) bus ();

  red_sequencer #(
    .ADDRESS_WIDTH (5),
    .ALUctrl_WIDTH (3),
    .DATA_WIDTH    (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .EQ       (EQ),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .ImmOp    (ImmOp),
    .RegWrite (RegWrite),
    .ALUsrc   (ALUsrc),
    .ALUctrl  (ALUctrl),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a fetch at addr, hold off for waits cycles, then return word.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int waits);
    int n;
    n = 0;
    while (bus.instr_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk1("fetch_req", bus.instr_req, 1'b1);
    chk("fetch_addr", bus.instr_addr, addr);
    for (int i = 0; i < waits; i++) begin
      bus.instr_rdata = 32'hFFFF_FFFF;
      tick();
      chk1("wait_req", bus.instr_req, 1'b1);
      chk("wait_addr", bus.instr_addr, addr);
    end
    bus.instr_valid = 1'b1;
    bus.instr_rdata = word;
    tick();
    bus.instr_valid = 1'b0;
    bus.instr_rdata = 32'hFFFF_FFFF;
    chk1("decode_req", bus.instr_req, 1'b0);
    chk1("decode_busy", busy, 1'b1);
  endtask

  task automatic run_addi(input logic [31:0] addr, input logic [31:0] word, input int waits,
                          input logic [4:0] exp_rd, input logic [31:0] exp_imm, input logic exp_we);
    logic [31:0] nxt;
    nxt = addr + 32'd4;
    fetch(addr, word, waits);
    chk("addi_rd", 32'(rd), 32'(exp_rd));
    chk("addi_imm", ImmOp, exp_imm);
    chk1("addi_alusrc", ALUsrc, 1'b1);
    chk("addi_aluctrl", 32'(ALUctrl), 32'd0);
    chk1("addi_we_decode", RegWrite, 1'b0);
    tick();
    chk1("addi_we_exec", RegWrite, exp_we);
    chk("addi_pc_exec", pc, addr);
    tick();
    chk1("addi_we_after", RegWrite, 1'b0);
    chk("addi_pc_next", pc, nxt);
  endtask

  task automatic run_bne(input logic [31:0] addr, input logic [31:0] word, input logic eq,
                         input logic [31:0] exp_imm, input logic [31:0] exp_pc,
                         input logic exp_halt, input logic exp_illegal);
    fetch(addr, word, 0);
    chk("bne_imm", ImmOp, exp_imm);
    chk1("bne_alusrc", ALUsrc, 1'b0);
    chk("bne_aluctrl", 32'(ALUctrl), 32'd1);
    tick();
    EQ = eq;
    chk1("bne_we_exec", RegWrite, 1'b0);
    tick();
    EQ = 1'b0;
    chk("bne_pc", pc, exp_pc);
    chk1("bne_halted", halted, exp_halt);
    chk1("bne_illegal", illegal, exp_illegal);
  endtask

  task automatic run_stop(input logic [31:0] addr, input logic [31:0] word, input logic exp_illegal);
    fetch(addr, word, 0);
    tick();
    chk1("stop_we_exec", RegWrite, 1'b0);
    tick();
    chk1("stop_halted", halted, 1'b1);
    chk1("stop_busy", busy, 1'b0);
    chk1("stop_illegal", illegal, exp_illegal);
    chk("stop_pc", pc, addr);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    EQ = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_rdata = 32'h0;
    #1 rst = 1'b1;
    #1;
    chk1("rst_we", RegWrite, 1'b0);
    chk1("rst_req", bus.instr_req, 1'b0);
    chk1("rst_illegal", illegal, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_imm", ImmOp, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk1("idle_busy", busy, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;

    // ADDI x10,x0,5 with a zero-wait response
    run_addi(32'h0, 32'h0050_0513, 0, 5'd10, 32'd5, 1'b1);
    // ADDI x2,x0,-1 with 3 wait cycles; start held high must be ignored
    start = 1'b1;
    run_addi(32'h4, 32'hFFF0_0113, 3, 5'd2, 32'hFFFF_FFFF, 1'b1);
    start = 1'b0;
    chk("bne_rs1_pending", bus.instr_addr, 32'h8);
    run_bne(32'h8, 32'hFE05_1EE3, 1'b0, 32'hFFFF_FFFC, 32'h4, 1'b0, 1'b0);
    run_addi(32'h4, 32'h0010_0093, 0, 5'd1, 32'd1, 1'b1);
    run_bne(32'h8, 32'hFE05_1EE3, 1'b1, 32'hFFFF_FFFC, 32'hC, 1'b0, 1'b0);
    // ADDI x0 must not write
    run_addi(32'hC, 32'h0050_0013, 0, 5'd0, 32'd5, 1'b0);
    // Taken branch to a half-word aligned target
    run_bne(32'h10, 32'h0000_1163, 1'b0, 32'h2, 32'h10, 1'b1, 1'b1);

    // instr_valid in HALT is ignored
    bus.instr_valid = 1'b1;
    bus.instr_rdata = 32'h0050_0513;
    tick();
    tick();
    bus.instr_valid = 1'b0;
    chk1("halt_hold", halted, 1'b1);
    chk1("halt_req", bus.instr_req, 1'b0);
    chk("halt_pc", pc, 32'h10);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_pc", pc, 32'h0);
    chk1("restart_illegal", illegal, 1'b0);
    chk1("restart_req", bus.instr_req, 1'b1);

    run_stop(32'h0, 32'h0010_0073, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_addi(32'h0, 32'h0050_0513, 2, 5'd10, 32'd5, 1'b1);
    run_stop(32'h4, 32'hFFFF_FFFF, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart2_pc", pc, 32'h0);
    chk("restart2_addr", bus.instr_addr, 32'h0);
    chk1("restart2_illegal", illegal, 1'b0);

    // Wrap: branch back from 0 to 0xFFFFFFFC, then +4 wraps to 0
    run_bne(32'h0, 32'hFE05_1EE3, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0);
    run_addi(32'hFFFF_FFFC, 32'h0010_0093, 0, 5'd1, 32'd1, 1'b1);
    run_addi(32'h0, 32'h0050_0513, 0, 5'd10, 32'd5, 1'b1);

    // Reset in the middle of EXEC of ADDI x1
    fetch(32'h4, 32'h0010_0093, 0);
    tick();
    chk1("pre_rst_we", RegWrite, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("mid_rst_we", RegWrite, 1'b0);
    chk("mid_rst_pc", pc, 32'h0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rd", 32'(rd), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk1("post_rst_req", bus.instr_req, 1'b0);
    chk1("post_rst_busy", busy, 1'b0);
    chk("post_rst_pc", pc, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk1("post_rst_start", bus.instr_req, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
